// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and the 8-to-3 fixed-priority encoder
// used by the round-robin arbiter.
package arb_pkg;
    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Lowest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] pri_enc8(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [HOLD_W-1:0] hold_cnt;

    modport master (input req, output gnt, output gnt_idx, output gnt_valid, output hold_cnt);
    modport slave  (output req, input gnt, input gnt_idx, input gnt_valid, input hold_cnt);
endinterface

// File: rtl/rr_arbiter8_pick.sv
// Combinational rotating-priority pick: search starts at ptr and wraps mod 8,
// with an optional single masked requester.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] mask_idx,
    input  logic             mask_en,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx,
    output logic [N_REQ-1:0] win_onehot
);
    logic [N_REQ-1:0]   mask_vec;
    logic [N_REQ-1:0]   masked;
    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDX_W-1:0]   rot_idx;

    always_comb begin
        mask_vec   = mask_en ? (N_REQ'(1) << mask_idx) : '0;
        masked     = req & ~mask_vec;
        // Rotating right by ptr puts requester ptr at bit 0 of the encoder.
        doubled    = {masked, masked} >> ptr;
        rotated    = doubled[N_REQ-1:0];
        rot_idx    = pri_enc8(rotated);
        any        = |masked;
        win_idx    = any ? (rot_idx + ptr) : '0;
        win_onehot = any ? (N_REQ'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with a per-tenure hold limit;
// all outputs come straight from registers.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic          clk,
    input logic          rst,
    rr_arbiter8_if.master bus
);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_t        state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [IDX_W-1:0]  owner, owner_n;
    logic [N_REQ-1:0]  gnt_r, gnt_n;
    logic [HOLD_W-1:0] hold_r, hold_n;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_ptr;
    logic              owner_req;
    logic              others_req;
    logic              rotate;

    // While owning, the next candidate search always starts just past the
    // owner and skips it, so a release or forced rotation never re-picks it.
    assign pick_ptr = (state == OWN) ? owner + 3'd1 : ptr;

    rr_pick u_pick (
        .req        (bus.req),
        .mask_idx   (owner),
        .mask_en    (state == OWN),
        .ptr        (pick_ptr),
        .any        (pick_any),
        .win_idx    (pick_idx),
        .win_onehot (pick_onehot)
    );

    always_comb begin
        owner_req  = |(bus.req & gnt_r);
        others_req = |(bus.req & ~gnt_r);
        rotate     = (state == OWN) &&
                     (!owner_req || ((hold_r == HOLD_MAX) && others_req));

        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        gnt_n   = gnt_r;
        hold_n  = hold_r;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = OWN;
                    owner_n = pick_idx;
                    gnt_n   = pick_onehot;
                    hold_n  = HOLD_W'(1);
                end
            end
            OWN: begin
                if (rotate) begin
                    ptr_n = owner + 3'd1;
                    if (pick_any) begin
                        owner_n = pick_idx;
                        gnt_n   = pick_onehot;
                        hold_n  = HOLD_W'(1);
                    end else begin
                        state_n = IDLE;
                        owner_n = '0;
                        gnt_n   = '0;
                        hold_n  = '0;
                    end
                end else if (hold_r < HOLD_MAX) begin
                    hold_n = hold_r + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = '0;
                gnt_n   = '0;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            gnt_r  <= '0;
            hold_r <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            owner  <= owner_n;
            gnt_r  <= gnt_n;
            hold_r <= hold_n;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = owner;
    assign bus.gnt_valid = (state == OWN);
    assign bus.hold_cnt  = hold_r;
endmodule
